s2p: RTL and testbench

Serial-to-parallel converter: receives an LSB-first bit stream over a valid/ready serial handshake and delivers N-bit words over a valid/ready parallel handshake. It is the receive-side counterpart of the parallel-to-serial converter in the same AXI-Stream conversion path; a `p2s` → `s2p` loopback must reproduce the original words. Collection is double-buffered: the next word accumulates while the previous word waits for the downstream consumer.

---
 rtl/p2s_pkg.sv | 14 +
 rtl/s2p.sv | 142 ++++++++++++++
 tb/tb_s2p.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/p2s_pkg.sv
// p2s_pkg: definitions shared by the parallel-to-serial transmitter (p2s)
// and the serial-to-parallel receiver (s2p) of the stream conversion path.
//   state_t : converter state, COLLECT (taking bits) / PEND (word parked)
//   DEF_W   : default word width in bits
package p2s_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PEND    = 1'b1
  } state_t;

  localparam int DEF_W = 8;

endpackage

// File: rtl/s2p.sv
// s2p: serial-to-parallel converter. Collects an LSB-first bit stream over a
// valid/ready serial handshake and delivers N-bit words over a valid/ready
// parallel handshake. Double-buffered: while a finished word waits in the
// output register, the next word accumulates in the shift register.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   ser_valid/ser_data   serial bit in, first bit lands in par_data[0]
//   ser_ready            serial bit accepted when ser_valid && ser_ready
//   par_valid/par_data   output word
//   par_ready            word consumed when par_valid && par_ready
//   word_cnt             wrapping count of consumed words
module s2p
  import p2s_pkg::*;
#(
  parameter int N     = DEF_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic             par_valid,
  output logic [N-1:0]     par_data,
  input  logic             par_ready,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int N_BITS = $clog2(N);
  localparam logic [N_BITS-1:0] LAST_BIT = N_BITS'(N - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N-1:0]       r_sr;
  logic [N_BITS-1:0]  r_bit_cnt;
  logic [N-1:0]       r_out;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_word_cnt;

  logic               w_ser_acc;
  logic               w_par_hs;
  logic               w_last;
  logic               w_load_out;
  logic [N-1:0]       w_word;

  // ser_ready decodes only the registered state, so no combinational path
  // from par_ready or ser_valid reaches it.
  assign ser_ready  = (r_state == COLLECT);
  assign w_ser_acc  = ser_valid && ser_ready;
  assign w_par_hs   = r_out_valid && par_ready;
  assign w_last     = (r_bit_cnt == LAST_BIT);
  assign w_word     = {ser_data, r_sr[N-1:1]};
  // A completed word goes straight to the output when the output register
  // is empty or being emptied at this same edge.
  assign w_load_out = w_ser_acc && w_last && (!r_out_valid || w_par_hs);

  assign par_valid = r_out_valid;
  assign par_data  = r_out;
  assign word_cnt  = r_word_cnt;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: park a finished word when the output is still busy.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: begin
        if (w_ser_acc && w_last && !w_load_out) begin
          w_state_nxt = PEND;
        end else begin
          w_state_nxt = COLLECT;
        end
      end
      PEND: begin
        if (w_par_hs) begin
          w_state_nxt = COLLECT;
        end else begin
          w_state_nxt = PEND;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Shift register and bit counter; a parked word simply stays in r_sr
  // because no bits are accepted in PEND.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sr      <= {N{1'b0}};
      r_bit_cnt <= {N_BITS{1'b0}};
    end else if (w_ser_acc) begin
      r_sr <= w_word;
      if (w_last) begin
        r_bit_cnt <= {N_BITS{1'b0}};
      end else begin
        r_bit_cnt <= r_bit_cnt + N_BITS'(1);
      end
    end else begin
      r_sr      <= r_sr;
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // Output register: load a fresh word, refill from the parked word, or
  // empty on a handshake with no replacement.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out       <= {N{1'b0}};
      r_out_valid <= 1'b0;
    end else if (w_load_out) begin
      r_out       <= w_word;
      r_out_valid <= 1'b1;
    end else if ((r_state == PEND) && w_par_hs) begin
      r_out       <= r_sr;
      r_out_valid <= 1'b1;
    end else if (w_par_hs) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out       <= r_out;
      r_out_valid <= r_out_valid;
    end
  end

  // Consumed-word counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_word_cnt <= {CNT_W{1'b0}};
    end else if (w_par_hs) begin
      r_word_cnt <= r_word_cnt + CNT_W'(1);
    end else begin
      r_word_cnt <= r_word_cnt;
    end
  end

endmodule

// File: tb/tb_s2p.sv
// tb_s2p: self-checking bench for s2p (N=8). Main DUT uses CNT_W=16; a
// second instance with CNT_W=4 shares all inputs to exercise counter wrap.
// Inputs are driven on the falling edge; outputs are sampled there too.
module tb_s2p;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ser_valid = 1'b0;
  logic        ser_data = 1'b0;
  logic        ser_ready;
  logic        par_valid;
  logic [7:0]  par_data;
  logic        par_ready = 1'b0;
  logic [15:0] word_cnt;

  logic        ser_ready4;
  logic        par_valid4;
  logic [7:0]  par_data4;
  logic [3:0]  word_cnt4;

  int n_chk = 0;
  int n_err = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  s2p #(.N(8), .CNT_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_ready(ser_ready), .par_valid(par_valid), .par_data(par_data),
    .par_ready(par_ready), .word_cnt(word_cnt)
  );

  s2p #(.N(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_ready(ser_ready4), .par_valid(par_valid4), .par_data(par_data4),
    .par_ready(par_ready), .word_cnt(word_cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends one word LSB first on consecutive cycles, then idles the serial
  // side; returns at the falling edge after the 8th accept.
  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ser_valid = 1'b1;
      ser_data  = w[i];
    end
    @(negedge clk);
    ser_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [7:0] lb_q[$];
    logic [7:0] tx_word;
    logic [7:0] gen;
    int         tx_bit;
    int         tx_left;
    int         rx_got;
    int         cyc;
    logic [7:0] w81;

    vecs[0] = '{8'hA5, 8'hA5};
    vecs[1] = '{8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF};
    vecs[3] = '{8'h5A, 8'h5A};
    vecs[4] = '{8'h01, 8'h01};
    vecs[5] = '{8'h80, 8'h80};

    // reset values
    #2;
    chk("rst_ser_ready", 32'(ser_ready), 32'd1);
    chk("rst_par_valid", 32'(par_valid), 32'd0);
    chk("rst_par_data", 32'(par_data), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // table-driven basic words, par_ready held high
    par_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].word);
      chk("basic_valid", 32'(par_valid), 32'd1);
      chk("basic_data", 32'(par_data), 32'(vecs[v].exp_data));
      chk("basic_cnt_before", 32'(word_cnt), 32'(exp_cnt));
      @(negedge clk);
      exp_cnt++;
      chk("basic_valid_drop", 32'(par_valid), 32'd0);
      chk("basic_cnt_after", 32'(word_cnt), 32'(exp_cnt));
    end

    // back-pressure: 3C held while C3 parks in the shift register
    par_ready = 1'b0;
    send_word(8'h3C);
    chk("bp_first_valid", 32'(par_valid), 32'd1);
    chk("bp_first_data", 32'(par_data), 32'h3C);
    chk("bp_ready_open", 32'(ser_ready), 32'd1);
    send_word(8'hC3);
    chk("bp_ready_low", 32'(ser_ready), 32'd0);
    chk("bp_hold_data", 32'(par_data), 32'h3C);
    chk("bp_hold_valid", 32'(par_valid), 32'd1);
    // offered bits during PEND must be refused
    ser_valid = 1'b1;
    ser_data  = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_still_data", 32'(par_data), 32'h3C);
    chk("bp_still_ready", 32'(ser_ready), 32'd0);
    ser_valid = 1'b0;
    par_ready = 1'b1;
    @(negedge clk);
    par_ready = 1'b0;
    exp_cnt++;
    chk("bp_second_data", 32'(par_data), 32'hC3);
    chk("bp_second_valid", 32'(par_valid), 32'd1);
    chk("bp_ready_back", 32'(ser_ready), 32'd1);
    chk("bp_cnt", 32'(word_cnt), 32'(exp_cnt));
    par_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    chk("bp_drain_valid", 32'(par_valid), 32'd0);

    // valid gaps: 81 with ser_valid toggling, garbage data in the gaps
    par_ready = 1'b0;
    w81 = 8'h81;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ser_valid = 1'b1;
      ser_data  = w81[i];
      @(negedge clk);
      ser_valid = 1'b0;
      ser_data  = ~w81[i];
    end
    @(negedge clk);
    chk("gap_valid", 32'(par_valid), 32'd1);
    chk("gap_data", 32'(par_data), 32'h81);
    par_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    send_word(8'hA5);
    chk("gap_align_data", 32'(par_data), 32'hA5);
    @(negedge clk);
    exp_cnt++;
    chk("gap_cnt", 32'(word_cnt), 32'(exp_cnt));

    // reset mid-word
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ser_valid = 1'b1;
      ser_data  = 1'b1;
    end
    @(negedge clk);
    ser_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(par_valid), 32'd0);
    chk("mid_rst_data", 32'(par_data), 32'd0);
    chk("mid_rst_cnt", 32'(word_cnt), 32'd0);
    chk("mid_rst_ready", 32'(ser_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    exp_cnt = 0;
    send_word(8'h0F);
    chk("mid_rst_word", 32'(par_data), 32'h0F);
    chk("mid_rst_word_valid", 32'(par_valid), 32'd1);
    @(negedge clk);
    chk("mid_rst_cnt1", 32'(word_cnt), 32'd1);

    // counter wrap on the CNT_W=4 instance
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_word(8'(i * 17));
    end
    @(negedge clk);
    chk("wrap_cnt4_zero", 32'(word_cnt4), 32'd0);
    chk("wrap_cnt16", 32'(word_cnt), 32'd16);
    send_word(8'h77);
    @(negedge clk);
    chk("wrap_cnt4_one", 32'(word_cnt4), 32'd1);

    // loopback through a bench serializer, random stalls on both sides
    do_reset();
    tx_left = 200;
    tx_bit  = 8;
    rx_got  = 0;
    cyc     = 0;
    tx_word = 8'h00;
    while (rx_got < 200 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (tx_bit == 8 && tx_left > 0) begin
        gen = 8'($urandom);
        tx_word = gen;
        lb_q.push_back(gen);
        tx_left--;
        tx_bit = 0;
      end
      ser_valid = (tx_bit < 8) && ($urandom_range(0, 3) != 0);
      ser_data  = (tx_bit < 8) ? tx_word[tx_bit[2:0]] : 1'($urandom);
      par_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (ser_valid && ser_ready) begin
        tx_bit++;
      end
      if (par_valid && par_ready) begin
        if (lb_q.size() == 0) begin
          chk("lb_extra_word", 32'(par_data), 32'hFFFF_FFFF);
        end else begin
          chk("lb_word", 32'(par_data), 32'(lb_q.pop_front()));
        end
        rx_got++;
      end
    end
    chk("lb_received", 32'(rx_got), 32'd200);
    @(negedge clk);
    ser_valid = 1'b0;
    par_ready = 1'b0;
    chk("lb_cnt", 32'(word_cnt), 32'd200);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
